// File: rtl/tcm_arb_pkg.sv
// Shared types for the two-requester TCM port arbiter.
package tcm_arb_pkg;

    localparam int TCM_WORD_BYTES = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  wr;
        logic [63:0] data;
    } tcm_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } tcm_resp_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

endpackage

// File: rtl/tcm_resp_hold.sv
// One-entry response holding register: passes a response straight through,
// or parks it when the owner is not ready and replays it until accepted.
module tcm_resp_hold
    import tcm_arb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      in_valid_i,
    input  tcm_resp_t in_resp_i,
    input  logic      ready_i,
    output logic      valid_o,
    output tcm_resp_t resp_o
);

    logic      full_q, full_d;
    tcm_resp_t held_q, held_d;

    // The arbiter never delivers a new response while this register is full.
    always_comb begin
        full_d = full_q;
        held_d = held_q;
        if (full_q) begin
            if (ready_i) full_d = 1'b0;
        end else if (in_valid_i && !ready_i) begin
            full_d = 1'b1;
            held_d = in_resp_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_q <= 1'b0;
            held_q <= '0;
        end else begin
            full_q <= full_d;
            held_q <= held_d;
        end
    end

    assign valid_o = full_q | in_valid_i;
    assign resp_o  = full_q ? held_q : (in_valid_i ? in_resp_i : '0);

endmodule

// File: rtl/tcm_port_arb.sv
// Round-robin arbiter sharing one 64-bit TCM port between requesters A and B.
// Define TCM_ARB_ERR_EN to add out-of-range error responses (a/b_resp_err_o).
module tcm_port_arb
    import tcm_arb_pkg::*;
#(
    parameter int TCM_MEM_DEPTH = 16,
    parameter int ADDR_W        = $clog2(TCM_MEM_DEPTH * 1024 / TCM_WORD_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic [31:0]       a_addr_i,
    input  logic [7:0]        a_wr_i,
    input  logic [63:0]       a_data_i,
    output logic              a_accept_o,
    output logic              a_resp_valid_o,
    output logic [63:0]       a_resp_data_o,
    input  logic              a_resp_ready_i,
`ifdef TCM_ARB_ERR_EN
    output logic              a_resp_err_o,
    output logic              b_resp_err_o,
`endif
    input  logic              b_req_i,
    input  logic [31:0]       b_addr_i,
    input  logic [7:0]        b_wr_i,
    input  logic [63:0]       b_data_i,
    output logic              b_accept_o,
    output logic              b_resp_valid_o,
    output logic [63:0]       b_resp_data_o,
    input  logic              b_resp_ready_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [63:0]       ram_data_o,
    output logic [7:0]        ram_wr_o,
    input  logic [63:0]       ram_data_i
);

    localparam int OFS_W = $clog2(TCM_WORD_BYTES);

    tcm_req_t          a_req, b_req, win;
    logic              a_elig, b_elig, gnt_a, gnt_b, gnt, win_err;
    logic [ADDR_W-1:0] win_addr;

    owner_e            ptr_q, ptr_d, pend_owner_q, pend_owner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              pend_q, pend_d, pend_rd_q, pend_rd_d, pend_err_q, pend_err_d;

    tcm_resp_t         pend_resp, a_rsp, b_rsp;
    logic              unused_bits;

    assign a_req = '{a_addr_i, a_wr_i, a_data_i};
    assign b_req = '{b_addr_i, b_wr_i, b_data_i};

    // A requester may issue only if its response slot is free next cycle.
    assign a_elig = rst_i & a_req_i & (~a_resp_valid_o | a_resp_ready_i);
    assign b_elig = rst_i & b_req_i & (~b_resp_valid_o | b_resp_ready_i);
    assign gnt_a  = a_elig & (~b_elig | (ptr_q == OWNER_A));
    assign gnt_b  = b_elig & (~a_elig | (ptr_q == OWNER_B));
    assign gnt    = gnt_a | gnt_b;

    assign a_accept_o = gnt_a;
    assign b_accept_o = gnt_b;

    assign win      = gnt_b ? b_req : a_req;
    assign win_addr = win.addr[ADDR_W+OFS_W-1:OFS_W];

`ifdef TCM_ARB_ERR_EN
    assign win_err = |win.addr[31:ADDR_W+OFS_W];
`else
    assign win_err = 1'b0;
`endif

    assign ram_addr_o = gnt ? win_addr : ram_addr_q;
    assign ram_data_o = gnt ? win.data : '0;
    assign ram_wr_o   = (gnt && !win_err) ? win.wr : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (a_elig && b_elig) ptr_d = (ptr_q == OWNER_A) ? OWNER_B : OWNER_A;
        ram_addr_d   = gnt ? win_addr : ram_addr_q;
        pend_d       = gnt;
        pend_owner_d = gnt_b ? OWNER_B : OWNER_A;
        pend_rd_d    = (win.wr == 8'h00) && !win_err;
        pend_err_d   = win_err;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q        <= OWNER_A;
            ram_addr_q   <= '0;
            pend_q       <= 1'b0;
            pend_owner_q <= OWNER_A;
            pend_rd_q    <= 1'b0;
            pend_err_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            ram_addr_q   <= ram_addr_d;
            pend_q       <= pend_d;
            pend_owner_q <= pend_owner_d;
            pend_rd_q    <= pend_rd_d;
            pend_err_q   <= pend_err_d;
        end
    end

    // RAM read data is only meaningful the cycle after a read was issued.
    assign pend_resp.data = pend_rd_q ? ram_data_i : '0;
    assign pend_resp.err  = pend_err_q;

    tcm_resp_hold u_hold_a (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (pend_q && (pend_owner_q == OWNER_A)),
        .in_resp_i  (pend_resp),
        .ready_i    (a_resp_ready_i),
        .valid_o    (a_resp_valid_o),
        .resp_o     (a_rsp)
    );

    tcm_resp_hold u_hold_b (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (pend_q && (pend_owner_q == OWNER_B)),
        .in_resp_i  (pend_resp),
        .ready_i    (b_resp_ready_i),
        .valid_o    (b_resp_valid_o),
        .resp_o     (b_rsp)
    );

    assign a_resp_data_o = a_rsp.data;
    assign b_resp_data_o = b_rsp.data;

`ifdef TCM_ARB_ERR_EN
    assign a_resp_err_o = a_rsp.err;
    assign b_resp_err_o = b_rsp.err;
    assign unused_bits  = ^win.addr[OFS_W-1:0];
`else
    assign unused_bits  = ^{win.addr[OFS_W-1:0], win.addr[31:ADDR_W+OFS_W], a_rsp.err, b_rsp.err};
`endif

endmodule

// File: tb/tb_tcm_port_arb.sv
// Bench for tcm_port_arb: directed table, hand sequences and a randomized run
// against a queue-based reference model.
module tb_tcm_port_arb;

    localparam int AW = 11;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          a_req_i, b_req_i, a_resp_ready_i, b_resp_ready_i;
    logic [31:0]   a_addr_i, b_addr_i;
    logic [7:0]    a_wr_i, b_wr_i;
    logic [63:0]   a_data_i, b_data_i;
    logic          a_accept_o, b_accept_o, a_resp_valid_o, b_resp_valid_o;
    logic [63:0]   a_resp_data_o, b_resp_data_o;
    logic [AW-1:0] ram_addr_o;
    logic [63:0]   ram_data_o, ram_data_i;
    logic [7:0]    ram_wr_o;
`ifdef TCM_ARB_ERR_EN
    logic          a_resp_err_o, b_resp_err_o;
`endif

    always #5 clk_i = ~clk_i;

    tcm_port_arb #(.TCM_MEM_DEPTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_wr_i(a_wr_i), .a_data_i(a_data_i),
        .a_accept_o(a_accept_o), .a_resp_valid_o(a_resp_valid_o),
        .a_resp_data_o(a_resp_data_o), .a_resp_ready_i(a_resp_ready_i),
`ifdef TCM_ARB_ERR_EN
        .a_resp_err_o(a_resp_err_o), .b_resp_err_o(b_resp_err_o),
`endif
        .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_wr_i(b_wr_i), .b_data_i(b_data_i),
        .b_accept_o(b_accept_o), .b_resp_valid_o(b_resp_valid_o),
        .b_resp_data_o(b_resp_data_o), .b_resp_ready_i(b_resp_ready_i),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
        .ram_data_i(ram_data_i)
    );

    // Read-first synchronous RAM with a backdoor preload port.
    logic [63:0]   mem [0:2047];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr;
    logic [63:0]   bd_data;
    always @(posedge clk_i) begin
        ram_data_i <= mem[ram_addr_o];
        if (bd_we) mem[bd_addr] <= bd_data;
        else for (int i = 0; i < 8; i++)
            if (ram_wr_o[i]) mem[ram_addr_o][i*8 +: 8] <= ram_data_o[i*8 +: 8];
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] mref [0:15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        a_req_i = 0; a_addr_i = 0; a_wr_i = 0; a_data_i = 0; a_resp_ready_i = 1;
        b_req_i = 0; b_addr_i = 0; b_wr_i = 0; b_data_i = 0; b_resp_ready_i = 1;
    endtask

    task automatic do_reset();
        @(negedge clk_i); idle(); rst_i = 0;
        @(negedge clk_i); rst_i = 1;
    endtask

    typedef struct {
        logic        ar, br;
        logic [31:0] aa, ba;
        logic [7:0]  bw;
        logic [63:0] bd;
        logic        ea, eb, erva, ervb;
        logic [7:0]  ewr;
        logic [10:0] eaddr;
        logic [63:0] ead, ebd;
    } vec_t;
    vec_t vecs[$];

    task automatic addv(input logic ar, br, input logic [31:0] aa, ba, input logic [7:0] bw,
                        input logic [63:0] bd, input logic ea, eb, erva, ervb,
                        input logic [7:0] ewr, input logic [10:0] eaddr, input logic [63:0] ead, ebd);
        vec_t v;
        v = '{ar, br, aa, ba, bw, bd, ea, eb, erva, ervb, ewr, eaddr, ead, ebd};
        vecs.push_back(v);
    endtask

    typedef struct { logic [63:0] data; logic err; } mresp_t;
    mresp_t qa[$], qb[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] wd, merged;
        idle();
        repeat (3) @(negedge clk_i);

        // Reset state, with requests present to show accepts are held off.
        a_req_i = 1; b_req_i = 1; #1;
        chk("rst_a_acc", a_accept_o, 0);
        chk("rst_b_acc", b_accept_o, 0);
        chk("rst_a_rv", a_resp_valid_o, 0);
        chk("rst_b_rv", b_resp_valid_o, 0);
        chk("rst_ram_wr", ram_wr_o, 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_a_data", a_resp_data_o, 0);
        chk("rst_b_data", b_resp_data_o, 0);
        idle();
        @(negedge clk_i); rst_i = 1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            wd = (i == 2) ? 64'h1122334455667788 :
                 (i == 1) ? 64'hAAAAAAAAAAAAAAAA : {32'hC0DE0000 | i, 32'h5A5A0000 + i * 32'h1111};
            bd_we = 1; bd_addr = AW'(i); bd_data = wd; mref[i] = wd;
        end
        @(negedge clk_i); bd_we = 0;

        // Single A read of word 2.
        @(negedge clk_i); a_req_i = 1; a_addr_i = 32'h10; #1;
        chk("rd_a_acc", a_accept_o, 1);
        chk("rd_ram_addr", ram_addr_o, 2);
        chk("rd_ram_wr", ram_wr_o, 0);
        @(negedge clk_i); idle(); #1;
        chk("rd_a_rv", a_resp_valid_o, 1);
        chk("rd_a_data", a_resp_data_o, 64'h1122334455667788);

        // B byte write then A read of the same word.
        @(negedge clk_i); b_req_i = 1; b_addr_i = 32'h8; b_wr_i = 8'h01; b_data_i = 64'hFF; #1;
        chk("wr_b_acc", b_accept_o, 1);
        chk("wr_ram_wr", ram_wr_o, 8'h01);
        chk("wr_ram_addr", ram_addr_o, 1);
        @(negedge clk_i); idle(); a_req_i = 1; a_addr_i = 32'h8; #1;
        chk("wr_a_acc", a_accept_o, 1);
        chk("wr_b_rv", b_resp_valid_o, 1);
        chk("wr_b_data", b_resp_data_o, 0);
        @(negedge clk_i); idle(); #1;
        mref[1][7:0] = 8'hFF;
        chk("wr_a_rv", a_resp_valid_o, 1);
        chk("wr_a_byte0", a_resp_data_o[7:0], 8'hFF);
        chk("wr_a_data", a_resp_data_o, mref[1]);

        // Directed table from a fresh reset (pointer at A).
        do_reset();
        merged = {mref[3][63:32], 32'hDEADBEEF};
        for (int k = 0; k < 6; k++)
            addv(1, 1, 32'h20, 32'h28, 0, 0, (k % 2 == 0), (k % 2 == 1),
                 (k > 0 && k % 2 == 1), (k > 0 && k % 2 == 0), 0, (k % 2 == 0) ? 11'd4 : 11'd5,
                 (k > 0 && k % 2 == 1) ? mref[4] : 64'h0, (k > 0 && k % 2 == 0) ? mref[5] : 64'h0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 11'd5, 0, mref[5]);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'd5, 0, 0);
        addv(0, 1, 0, 32'h18, 8'h0F, 64'h12345678DEADBEEF, 0, 1, 0, 0, 8'h0F, 11'd3, 0, 0);
        addv(1, 0, 32'h18, 0, 0, 0, 1, 0, 0, 1, 0, 11'd3, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 11'd3, merged, 0);
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk_i);
            a_req_i = vecs[k].ar; a_addr_i = vecs[k].aa; a_wr_i = 0; a_data_i = 0;
            b_req_i = vecs[k].br; b_addr_i = vecs[k].ba; b_wr_i = vecs[k].bw; b_data_i = vecs[k].bd;
            #1;
            chk($sformatf("tbl%0d_a_acc", k), a_accept_o, vecs[k].ea);
            chk($sformatf("tbl%0d_b_acc", k), b_accept_o, vecs[k].eb);
            chk($sformatf("tbl%0d_a_rv", k), a_resp_valid_o, vecs[k].erva);
            chk($sformatf("tbl%0d_b_rv", k), b_resp_valid_o, vecs[k].ervb);
            chk($sformatf("tbl%0d_ram_wr", k), ram_wr_o, vecs[k].ewr);
            chk($sformatf("tbl%0d_ram_addr", k), ram_addr_o, vecs[k].eaddr);
            chk($sformatf("tbl%0d_a_data", k), a_resp_data_o, vecs[k].ead);
            chk($sformatf("tbl%0d_b_data", k), b_resp_data_o, vecs[k].ebd);
        end
        mref[3] = merged;

        // A response back-pressured for 3 cycles while B streams.
        do_reset();
        @(negedge clk_i); idle(); a_req_i = 1; a_addr_i = 32'h10; #1;
        chk("bp_a_acc0", a_accept_o, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i); a_resp_ready_i = 0; b_req_i = 1; b_addr_i = 32'h28; #1;
            chk($sformatf("bp%0d_a_rv", k), a_resp_valid_o, 1);
            chk($sformatf("bp%0d_a_data", k), a_resp_data_o, mref[2]);
            chk($sformatf("bp%0d_a_acc", k), a_accept_o, 0);
            chk($sformatf("bp%0d_b_acc", k), b_accept_o, 1);
            if (k > 1) chk($sformatf("bp%0d_b_data", k), b_resp_data_o, mref[5]);
        end
        @(negedge clk_i); a_resp_ready_i = 1; #1;
        chk("bp4_a_acc", a_accept_o, 1);
        chk("bp4_b_acc", b_accept_o, 0);
        chk("bp4_a_data", a_resp_data_o, mref[2]);
        chk("bp4_b_rv", b_resp_valid_o, 1);
        @(negedge clk_i); idle(); #1;
        chk("bp5_a_rv", a_resp_valid_o, 1);
        chk("bp5_a_data", a_resp_data_o, mref[2]);
        chk("bp5_b_rv", b_resp_valid_o, 0);

        // Reset the cycle after an A accept; pointer had moved to B.
        do_reset();
        @(negedge clk_i); a_req_i = 1; b_req_i = 1; a_addr_i = 32'h10; b_addr_i = 32'h28; #1;
        chk("mr_a_acc0", a_accept_o, 1);
        @(negedge clk_i); b_req_i = 0; #1;
        chk("mr_a_acc1", a_accept_o, 1);
        @(negedge clk_i); rst_i = 0; #1;
        chk("mr_a_rv", a_resp_valid_o, 0);
        chk("mr_a_acc", a_accept_o, 0);
        chk("mr_ram_wr", ram_wr_o, 0);
        chk("mr_ram_addr", ram_addr_o, 0);
        chk("mr_a_data", a_resp_data_o, 0);
        @(negedge clk_i); rst_i = 1; b_req_i = 1; #1;
        chk("mr_ptr_a", a_accept_o, 1);
        chk("mr_ptr_b", b_accept_o, 0);
        chk("mr_rel_a_rv", a_resp_valid_o, 0);

        // Write above the RAM range.
        do_reset();
        @(negedge clk_i); idle(); a_req_i = 1; a_addr_i = 32'h4000; a_wr_i = 8'hFF;
        a_data_i = 64'h0BADF00D0BADF00D; #1;
        chk("hi_a_acc", a_accept_o, 1);
`ifdef TCM_ARB_ERR_EN
        chk("hi_ram_wr", ram_wr_o, 0);
`else
        chk("hi_ram_wr", ram_wr_o, 8'hFF);
        chk("hi_ram_addr", ram_addr_o, 0);
        mref[0] = 64'h0BADF00D0BADF00D;
`endif
        @(negedge clk_i); idle(); #1;
        chk("hi_a_rv", a_resp_valid_o, 1);
        chk("hi_a_data", a_resp_data_o, 0);
`ifdef TCM_ARB_ERR_EN
        chk("hi_a_err", a_resp_err_o, 1);
`endif

        // Randomized run against the queue model.
        do_reset();
        begin
            int          ptr;
            logic [10:0] last_addr;
            logic        a_el, b_el, ga, gb, err;
            logic [31:0] wa;
            logic [7:0]  ww;
            logic [63:0] wdat, rv;
            logic [7:0]  exp_wr;
            mresp_t      r;
            ptr = 0; last_addr = 0; qa.delete(); qb.delete();
            for (int c = 0; c < 400; c++) begin
                @(negedge clk_i);
                a_req_i = ($urandom_range(0, 9) < 7);
                b_req_i = ($urandom_range(0, 9) < 7);
                a_addr_i = {(($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'h0), 7'h0,
                            4'($urandom), 3'($urandom)};
                b_addr_i = {(($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'h0), 7'h0,
                            4'($urandom), 3'($urandom)};
                a_wr_i = $urandom_range(0, 1) ? 8'($urandom) : 8'h0;
                b_wr_i = $urandom_range(0, 1) ? 8'($urandom) : 8'h0;
                a_data_i = {$urandom, $urandom};
                b_data_i = {$urandom, $urandom};
                a_resp_ready_i = ($urandom_range(0, 3) != 0);
                b_resp_ready_i = ($urandom_range(0, 3) != 0);
                #1;
                chk($sformatf("rnd%0d_a_rv", c), a_resp_valid_o, qa.size() > 0);
                chk($sformatf("rnd%0d_b_rv", c), b_resp_valid_o, qb.size() > 0);
                chk($sformatf("rnd%0d_a_data", c), a_resp_data_o, qa.size() > 0 ? qa[0].data : 64'h0);
                chk($sformatf("rnd%0d_b_data", c), b_resp_data_o, qb.size() > 0 ? qb[0].data : 64'h0);
`ifdef TCM_ARB_ERR_EN
                chk($sformatf("rnd%0d_a_err", c), a_resp_err_o, qa.size() > 0 ? qa[0].err : 1'b0);
                chk($sformatf("rnd%0d_b_err", c), b_resp_err_o, qb.size() > 0 ? qb[0].err : 1'b0);
`endif
                a_el = a_req_i && (qa.size() == 0 || a_resp_ready_i);
                b_el = b_req_i && (qb.size() == 0 || b_resp_ready_i);
                ga = a_el && (!b_el || ptr == 0);
                gb = b_el && (!a_el || ptr == 1);
                if (a_el && b_el) ptr = 1 - ptr;
                wa = gb ? b_addr_i : a_addr_i;
                ww = gb ? b_wr_i : a_wr_i;
                wdat = gb ? b_data_i : a_data_i;
`ifdef TCM_ARB_ERR_EN
                err = (wa[31:14] != 0);
`else
                err = 1'b0;
`endif
                exp_wr = ((ga || gb) && !err) ? ww : 8'h0;
                if (ga || gb) last_addr = {7'h0, wa[6:3]};
                chk($sformatf("rnd%0d_a_acc", c), a_accept_o, ga);
                chk($sformatf("rnd%0d_b_acc", c), b_accept_o, gb);
                chk($sformatf("rnd%0d_ram_wr", c), ram_wr_o, exp_wr);
                chk($sformatf("rnd%0d_ram_addr", c), ram_addr_o, last_addr);
                if (qa.size() > 0 && a_resp_ready_i) void'(qa.pop_front());
                if (qb.size() > 0 && b_resp_ready_i) void'(qb.pop_front());
                if (ga || gb) begin
                    rv = mref[wa[6:3]];
                    r.data = (ww == 0 && !err) ? rv : 64'h0;
                    r.err = err;
                    if (ga) qa.push_back(r); else qb.push_back(r);
                    if (!err)
                        for (int i = 0; i < 8; i++)
                            if (ww[i]) mref[wa[6:3]][i*8 +: 8] = wdat[i*8 +: 8];
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcm_port_arb.md
Name: tcm_port_arb

Overview:
- Shares one 64-bit TCM RAM port (1-cycle synchronous read, byte-lane write strobes) between two requesters: A (CPU data side) and B (DMA/external bus slave).
- Round-robin grant, one request per cycle.
- Returns each read or write completion to its owner.
- Per-requester 1-entry response holding register absorbs response back-pressure.

Parameters:
- TCM_MEM_DEPTH, 16, RAM size in KByte.
- ADDR_W, $clog2(TCM_MEM_DEPTH*1024/8), RAM word-address width (derived; do not override).

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-low reset
- a_req_i  in  1  requester A request valid
- a_addr_i  in  32  A byte address
- a_wr_i  in  8  A byte write strobes; 0 = read
- a_data_i  in  64  A write data
- a_accept_o  out  1  A request taken this cycle
- a_resp_valid_o  out  1  A response valid
- a_resp_data_o  out  64  A read data; 0 for writes
- a_resp_ready_i  in  1  A can take response
- b_req_i, b_addr_i, b_wr_i, b_data_i, b_accept_o, b_resp_valid_o, b_resp_data_o, b_resp_ready_i: same widths and meaning for requester B
- ram_addr_o  out  ADDR_W  RAM word address = granted addr[ADDR_W+2:3]
- ram_data_o  out  64  RAM write data
- ram_wr_o  out  8  RAM byte strobes; 0 when idle or for a read
- ram_data_i  in  64  RAM read data, valid the cycle after the address is issued

Behaviour:
- Reset values: all *_accept_o, *_resp_valid_o and ram_wr_o are 0; resp data outputs 0; round-robin pointer = A; holding registers empty.
- Eligibility: X is eligible when x_req_i=1 and X's holding register is empty, or is being drained this cycle (x_resp_valid_o & x_resp_ready_i).
- Grant:
  - Only one requester eligible: it wins.
  - Both eligible: the pointer owner wins, and the pointer moves to the other requester.
  - Pointer changes only on a contested grant.
- x_accept_o is combinational and equals the grant. The RAM port is driven combinationally from the winner's fields. With no grant, ram_wr_o=0 and ram_addr_o holds its last value (registered mux select).
- Response path:
  - Registered owner tag plus valid flag (pend_q) in cycle N.
  - Cycle N+1: the response is presented to the owner. Read data = ram_data_i; write data = 0.
  - Latency is exactly 1 cycle from accept to resp_valid when the owner is ready.
- Back-pressure:
  - If the owner's resp_ready_i is 0 in N+1, the response (including ram_data_i) is captured in the owner's holding register.
  - resp_valid_o stays 1, with stable data, until ready is seen.
  - The held response has priority over any later response for that owner. That cannot occur, because eligibility blocks new grants while the register is full.
- Same-cycle drain and grant: allowed. The next response arrives the following cycle, giving zero bubble.
- Throughput: one transaction per cycle total. Alternating A/B under contention gives each 50%.
- Same-address hazards between A and B need no special handling: RAM read-first semantics apply, and ordering is grant order.
- Reset mid-operation clears pend_q and the holding registers. In-flight responses are dropped; the RAM write already issued stands.
- Unused low address bits [2:0] and bits above ADDR_W+2 are ignored unless TCM_ARB_ERR_EN is defined.

Optional Feature:
- Macro: TCM_ARB_ERR_EN.
- Defined:
  - Adds a_resp_err_o and b_resp_err_o (1 bit each).
  - A request with any addr bit above ADDR_W+2 set is accepted normally but drives ram_wr_o=0 (no RAM access).
  - Its response carries err=1 and data 0, with the same latency and holding rules.
- Undefined: the err ports are absent; high address bits alias into the RAM.

Decomposition:
- Package tcm_arb_pkg holds:
  - typedef tcm_req_t {addr[31:0], wr[7:0], data[63:0]}
  - typedef tcm_resp_t {data[63:0], err}
  - enum owner_e {OWNER_A, OWNER_B}
  - localparam TCM_WORD_BYTES=8
- One natural sub-module, tcm_resp_hold: a 1-entry response holding register with valid/ready. It is instantiated once per requester.

Test Plan:
- A read to addr 0x10 alone, RAM word 2 preloaded 0x1122334455667788 -> a_accept_o same cycle, ram_addr_o=2, a_resp_valid_o next cycle with data 0x1122334455667788.
- A and B both request every cycle for 6 cycles, pointer=A -> grants alternate A,B,A,B,A,B; each response arrives 1 cycle after its accept.
- B writes 0xFF at addr 0x8 with b_wr_i=0x01, then A reads 0x8 next cycle -> ram_wr_o=0x01 on B's cycle; A's read data byte0=0xFF.
- A read with a_resp_ready_i=0 for 3 cycles, A still requesting -> a_resp_valid_o stays 1 with stable data and a_accept_o=0 throughout. B requests are granted every cycle meanwhile. When ready=1, A is re-accepted the same cycle.
- Reset asserted (rst_i=0) the cycle after an A accept -> no a_resp_valid_o; all outputs 0; after release the pointer=A.
- TCM_ARB_ERR_EN, TCM_MEM_DEPTH=16, A write to 0x4000 -> ram_wr_o=0, a_resp_err_o=1 next cycle.
